id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register of the RISC-V core, sitting directly upstream of the ALU. It captures a decoded instruction and resolves both source operands through EX and WB forwarding. It selects immediate versus register for operand B and presents registered operands plus a 4-bit ALU opcode to the ALU. It also detects load-use hazards, stalls decode for them, and counts stall cycles.

## Interface
- No parameters; data width fixed at 32, register address width fixed at 5.
- clk  in  1  single clock; everything is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the held instruction and refuse the incoming one this cycle.
- in_valid / in_ready  in / out  1 / 1  decode handshake.
- in_rs1_addr, in_rs2_addr  in  5  source register numbers.
- in_rs1_data, in_rs2_data  in  32  register-file read data.
- in_imm  in  32  sign-extended immediate.
- in_use_imm  in  1  operand B is the immediate.
- in_uses_rs1, in_uses_rs2  in  1  instruction actually reads rs1 / rs2.
- in_alu_op  in  4  ALU opcode using the shared ALU definition codes: ADD, SUB, AND, OR, SLL, SRA.
- in_rd_addr  in  5  destination register.
- in_rd_wen  in  1  destination register is written.
- in_is_load  in  1  instruction is a load.
- fwd_ex_rd, fwd_ex_wen, fwd_ex_data, fwd_ex_is_load  in  5/1/32/1  result of the instruction now in EX/MEM.
- fwd_wb_rd, fwd_wb_wen, fwd_wb_data  in  5/1/32  result being written back this cycle.
- out_valid / out_ready  out / in  1 / 1  execute handshake.
- out_op_a, out_op_b  out  32  ALU operands rs1 and rs2.
- out_store_data  out  32  forwarded rs2 value, always; operand B may instead carry the immediate.
- out_alu_op  out  4  registered ALU opcode.
- out_rd_addr, out_rd_wen, out_is_load  out  5/1/1  registered destination information.
- stall_count  out  32  number of load-use stall cycles; saturates at 0xFFFFFFFF.

## Operation
- State machine has two states. EMPTY means out_valid=0; FULL means out_valid=1.
- load_use = in_valid & fwd_ex_is_load & fwd_ex_wen & (fwd_ex_rd≠0) & ((in_uses_rs1 & rs1 match) | (in_uses_rs2 & rs2 match)).
- in_ready = !flush & !load_use & (!out_valid | out_ready). The signal is combinational.
- Accept occurs when in_valid & in_ready. On accept, the register loads the resolved operands and controls and moves to or stays in FULL.
- Operand resolution is done separately for rs1 and rs2:
  - Register x0 always resolves to 0 and is never forwarded.
  - Otherwise EX wins if fwd_ex_wen & fwd_ex_rd matches.
  - Otherwise WB wins if fwd_wb_wen & fwd_wb_rd matches.
  - Otherwise the register-file data is used.
- out_op_b = in_use_imm ? in_imm : resolved rs2. out_store_data = resolved rs2.
- The block does no arithmetic and no masking; shift-amount truncation belongs to the ALU.
- Drain: when out_valid & out_ready & !accept, the block goes to EMPTY.
- Flush: the next state is EMPTY. The incoming instruction is refused because in_ready=0. stall_count is unchanged.
- stall_count increments by 1 on each cycle where load_use=1 and flush=0. It saturates and does not wrap.
- Reset mid-operation discards the held instruction with no partial update.

## Timing
- Reset values: out_valid=0. out_op_a, out_op_b, out_store_data and stall_count are 0. out_alu_op=ADD code. out_rd_addr=0, out_rd_wen=0, out_is_load=0.
- Latency is 1 cycle: an instruction accepted at edge N is presented with out_valid=1 after edge N.
- Throughput is 1 instruction per cycle when out_ready=1 and there are no hazards.
- Payload outputs are stable while out_valid=1 and out_ready=0.
- A load-use hazard costs exactly 1 bubble cycle. In the next cycle the load has left EX and its data arrives through WB forwarding.
- Simultaneous flush and load_use: flush dominates and the counter does not increment.
- Simultaneous drain and accept: the block stays FULL and the new payload replaces the old one.

## Test plan
- Reset then idle: all outputs hold their reset values. Accepting ADD x3=x1(5)+x2(7) from the register file gives out_op_a=5 and out_op_b=7 one cycle later.
- Forwarding priority: rs1=x4 with EX=(x4,0xAAAA) and WB=(x4,0xBBBB) gives out_op_a=0xAAAA. With EX removed, out_op_a=0xBBBB. With rs1=x0 and EX=(x0,0x1234), out_op_a=0.
- Load-use: EX holds a load to x5 and the incoming SUB reads x5. in_ready=0 for 1 cycle and stall_count 0→1. The next cycle it is accepted, taking WB data 0x55.
- Backpressure: out_ready=0 for 3 cycles with a new instruction waiting. The outputs do not change and in_ready=0. When out_ready rises, the waiting instruction is accepted that same cycle.
- Flush: FULL with flush=1 and in_valid=1 gives out_valid=0 next cycle and no accept. With flush=1 and a simultaneous hazard, stall_count is unchanged.
- Immediate select: SLL with in_use_imm=1 and imm=0x23 gives out_op_b=0x23 and out_store_data equal to the resolved rs2.

Source files
------------

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : decode-to-execute pipeline register with operand forwarding,
//               immediate select, load-use hazard detection and stall counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  // decode side
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic        in_uses_rs1,
  input  logic        in_uses_rs2,
  input  logic [3:0]  in_alu_op,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_rd_wen,
  input  logic        in_is_load,
  // forwarding sources
  input  logic [4:0]  fwd_ex_rd,
  input  logic        fwd_ex_wen,
  input  logic [31:0] fwd_ex_data,
  input  logic        fwd_ex_is_load,
  input  logic [4:0]  fwd_wb_rd,
  input  logic        fwd_wb_wen,
  input  logic [31:0] fwd_wb_data,
  // execute side
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  output logic [31:0] out_store_data,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd_addr,
  output logic        out_rd_wen,
  output logic        out_is_load,
  output logic [31:0] stall_count
);

  localparam logic [3:0]  c_ALU_ADD  = 4'd0;
  localparam logic [0:0]  c_EMPTY    = 1'b0;
  localparam logic [0:0]  c_FULL     = 1'b1;
  localparam logic [31:0] c_CNT_MAX  = 32'hFFFF_FFFF;

  logic [0:0]  r_state;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_store_data;
  logic [3:0]  r_alu_op;
  logic [4:0]  r_rd_addr;
  logic        r_rd_wen;
  logic        r_is_load;
  logic [31:0] r_stall_count;

  logic        w_rs1_nz;
  logic        w_rs2_nz;
  logic        w_rs1_ex_hit;
  logic        w_rs2_ex_hit;
  logic        w_rs1_wb_hit;
  logic        w_rs2_wb_hit;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic        w_load_use;
  logic        w_full;
  logic        w_accept;

  assign w_rs1_nz     = (in_rs1_addr != 5'd0);
  assign w_rs2_nz     = (in_rs2_addr != 5'd0);
  assign w_rs1_ex_hit = w_rs1_nz && fwd_ex_wen && (fwd_ex_rd == in_rs1_addr);
  assign w_rs2_ex_hit = w_rs2_nz && fwd_ex_wen && (fwd_ex_rd == in_rs2_addr);
  assign w_rs1_wb_hit = w_rs1_nz && fwd_wb_wen && (fwd_wb_rd == in_rs1_addr);
  assign w_rs2_wb_hit = w_rs2_nz && fwd_wb_wen && (fwd_wb_rd == in_rs2_addr);

  // EX is younger than WB, so it takes priority; x0 is hard-wired to zero.
  always_comb begin
    w_rs1_val = in_rs1_data;
    if (!w_rs1_nz)         w_rs1_val = 32'd0;
    else if (w_rs1_ex_hit) w_rs1_val = fwd_ex_data;
    else if (w_rs1_wb_hit) w_rs1_val = fwd_wb_data;
  end

  always_comb begin
    w_rs2_val = in_rs2_data;
    if (!w_rs2_nz)         w_rs2_val = 32'd0;
    else if (w_rs2_ex_hit) w_rs2_val = fwd_ex_data;
    else if (w_rs2_wb_hit) w_rs2_val = fwd_wb_data;
  end

  // A load in EX has no data yet; the dependent instruction waits one cycle
  // and then picks the value up from WB.
  assign w_load_use = in_valid && fwd_ex_is_load && fwd_ex_wen && (fwd_ex_rd != 5'd0) &&
                      ((in_uses_rs1 && (fwd_ex_rd == in_rs1_addr)) ||
                       (in_uses_rs2 && (fwd_ex_rd == in_rs2_addr)));

  assign w_full   = (r_state == c_FULL);
  assign in_ready = !flush && !w_load_use && (!w_full || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_EMPTY;
      r_op_a       <= 32'd0;
      r_op_b       <= 32'd0;
      r_store_data <= 32'd0;
      r_alu_op     <= c_ALU_ADD;
      r_rd_addr    <= 5'd0;
      r_rd_wen     <= 1'b0;
      r_is_load    <= 1'b0;
    end else if (flush) begin
      r_state <= c_EMPTY;
    end else if (w_accept) begin
      r_state      <= c_FULL;
      r_op_a       <= w_rs1_val;
      r_op_b       <= in_use_imm ? in_imm : w_rs2_val;
      r_store_data <= w_rs2_val;
      r_alu_op     <= in_alu_op;
      r_rd_addr    <= in_rd_addr;
      r_rd_wen     <= in_rd_wen;
      r_is_load    <= in_is_load;
    end else if (w_full && out_ready) begin
      r_state <= c_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= 32'd0;
    end else if (w_load_use && !flush && (r_stall_count != c_CNT_MAX)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign out_valid      = w_full;
  assign out_op_a       = r_op_a;
  assign out_op_b       = r_op_b;
  assign out_store_data = r_store_data;
  assign out_alu_op     = r_alu_op;
  assign out_rd_addr    = r_rd_addr;
  assign out_rd_wen     = r_rd_wen;
  assign out_is_load    = r_is_load;
  assign stall_count    = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed and randomized checks of id_ex_stage against a
//                  behavioural reference model.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_use_imm, in_uses_rs1, in_uses_rs2;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd_addr;
  logic        in_rd_wen, in_is_load;
  logic [4:0]  fwd_ex_rd;
  logic        fwd_ex_wen;
  logic [31:0] fwd_ex_data;
  logic        fwd_ex_is_load;
  logic [4:0]  fwd_wb_rd;
  logic        fwd_wb_wen;
  logic [31:0] fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op_a, out_op_b, out_store_data;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd_addr;
  logic        out_rd_wen, out_is_load;
  logic [31:0] stall_count;

  localparam logic [3:0] c_ADD = 4'd0, c_SUB = 4'd1, c_SLL = 4'd4;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_alu_op(in_alu_op), .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load),
    .fwd_ex_rd(fwd_ex_rd), .fwd_ex_wen(fwd_ex_wen), .fwd_ex_data(fwd_ex_data),
    .fwd_ex_is_load(fwd_ex_is_load),
    .fwd_wb_rd(fwd_wb_rd), .fwd_wb_wen(fwd_wb_wen), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_store_data(out_store_data),
    .out_alu_op(out_alu_op), .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen),
    .out_is_load(out_is_load), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic        m_valid;
  logic [31:0] m_a, m_b, m_sd, m_stall;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_wen, m_load;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
    if (fwd_ex_wen && fwd_ex_rd == r) return fwd_ex_data;
    if (fwd_wb_wen && fwd_wb_rd == r) return fwd_wb_data;
    return rf;
  endfunction

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_use_imm = 0; in_uses_rs1 = 0; in_uses_rs2 = 0;
    in_alu_op = c_ADD; in_rd_addr = 0; in_rd_wen = 0; in_is_load = 0;
    fwd_ex_rd = 0; fwd_ex_wen = 0; fwd_ex_data = 0; fwd_ex_is_load = 0;
    fwd_wb_rd = 0; fwd_wb_wen = 0; fwd_wb_data = 0;
  endtask

  // Check current outputs against the model, then advance model and DUT one edge.
  task automatic step();
    logic lu, rdy, acc;
    #1;
    lu = in_valid && fwd_ex_is_load && fwd_ex_wen && (fwd_ex_rd != 0) &&
         ((in_uses_rs1 && fwd_ex_rd == in_rs1_addr) || (in_uses_rs2 && fwd_ex_rd == in_rs2_addr));
    rdy = !flush && !lu && (!m_valid || out_ready);
    acc = in_valid && rdy;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("op_a", out_op_a, m_a);
    chk("op_b", out_op_b, m_b);
    chk("store_data", out_store_data, m_sd);
    chk("ctrl", {23'd0, out_alu_op, out_rd_addr, out_rd_wen, out_is_load},
                {23'd0, m_op, m_rd, m_wen, m_load});
    chk("stall_count", stall_count, m_stall);
    if (rst) begin
      m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_op = c_ADD;
      m_rd = 0; m_wen = 0; m_load = 0; m_stall = 0;
    end else begin
      if (lu && !flush && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1;
        m_a  = resolve(in_rs1_addr, in_rs1_data);
        m_sd = resolve(in_rs2_addr, in_rs2_data);
        m_b  = in_use_imm ? in_imm : m_sd;
        m_op = in_alu_op; m_rd = in_rd_addr; m_wen = in_rd_wen; m_load = in_is_load;
      end else if (m_valid && out_ready) m_valid = 0;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_op = c_ADD;
    m_rd = 0; m_wen = 0; m_load = 0; m_stall = 0;
    idle();
    @(posedge clk); #2;
    rst = 1; step(); step();
    idle(); step();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_alu_op", {28'd0, out_alu_op}, {28'd0, c_ADD});

    // ADD x3 = x1(5) + x2(7) from the register file
    in_valid = 1; in_rs1_addr = 1; in_rs2_addr = 2; in_rs1_data = 5; in_rs2_data = 7;
    in_uses_rs1 = 1; in_uses_rs2 = 1; in_rd_addr = 3; in_rd_wen = 1; in_alu_op = c_ADD;
    step();
    chk("add_op_a", out_op_a, 32'd5);
    chk("add_op_b", out_op_b, 32'd7);

    // forwarding priority
    in_rs1_addr = 4; in_rs1_data = 32'h1111;
    fwd_ex_rd = 4; fwd_ex_wen = 1; fwd_ex_data = 32'hAAAA;
    fwd_wb_rd = 4; fwd_wb_wen = 1; fwd_wb_data = 32'hBBBB;
    step();
    chk("fwd_ex_wins", out_op_a, 32'hAAAA);
    fwd_ex_wen = 0;
    step();
    chk("fwd_wb", out_op_a, 32'hBBBB);
    in_rs1_addr = 0; fwd_ex_rd = 0; fwd_ex_wen = 1; fwd_ex_data = 32'h1234;
    fwd_wb_rd = 0;
    step();
    chk("fwd_x0", out_op_a, 32'd0);

    // load-use: load to x5 in EX, SUB reads x5
    idle();
    in_valid = 1; in_alu_op = c_SUB; in_rs1_addr = 5; in_rs2_addr = 0; in_uses_rs1 = 1;
    in_rd_addr = 6; in_rd_wen = 1;
    fwd_ex_rd = 5; fwd_ex_wen = 1; fwd_ex_is_load = 1; fwd_ex_data = 32'hDEAD;
    #1 chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("lu_stall", stall_count, 32'd1);
    fwd_ex_wen = 0; fwd_ex_is_load = 0; fwd_wb_rd = 5; fwd_wb_wen = 1; fwd_wb_data = 32'h55;
    step();
    chk("lu_wb_data", out_op_a, 32'h55);
    chk("lu_valid", {31'd0, out_valid}, 32'd1);

    // backpressure for three cycles with a waiting instruction
    idle();
    in_valid = 1; in_rs1_addr = 7; in_rs1_data = 32'h77; in_alu_op = c_SUB; out_ready = 0;
    step(); step(); step();
    out_ready = 1;
    step();
    chk("bp_accept", out_op_a, 32'h77);

    // flush while FULL, then flush with simultaneous hazard
    in_valid = 1; flush = 1; in_rs1_addr = 8; in_rs1_data = 32'h88;
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    in_uses_rs1 = 1; fwd_ex_rd = 8; fwd_ex_wen = 1; fwd_ex_is_load = 1;
    step();
    chk("flush_stall", stall_count, 32'd1);

    // immediate select
    idle();
    in_valid = 1; in_alu_op = c_SLL; in_use_imm = 1; in_imm = 32'h23;
    in_rs2_addr = 6; in_rs2_data = 32'h99; in_rs1_addr = 1; in_rs1_data = 32'h3;
    step();
    chk("imm_op_b", out_op_b, 32'h23);
    chk("imm_store", out_store_data, 32'h99);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      in_rs1_addr    = 5'($urandom_range(0, 3));
      in_rs2_addr    = 5'($urandom_range(0, 3));
      in_rs1_data    = $urandom;
      in_rs2_data    = $urandom;
      in_imm         = $urandom;
      in_use_imm     = 1'($urandom_range(0, 1));
      in_uses_rs1    = 1'($urandom_range(0, 1));
      in_uses_rs2    = 1'($urandom_range(0, 1));
      in_alu_op      = 4'($urandom_range(0, 5));
      in_rd_addr     = 5'($urandom);
      in_rd_wen      = 1'($urandom_range(0, 1));
      in_is_load     = 1'($urandom_range(0, 1));
      fwd_ex_rd      = 5'($urandom_range(0, 3));
      fwd_ex_wen     = 1'($urandom_range(0, 1));
      fwd_ex_data    = $urandom;
      fwd_ex_is_load = ($urandom_range(0, 2) == 0);
      fwd_wb_rd      = 5'($urandom_range(0, 3));
      fwd_wb_wen     = 1'($urandom_range(0, 1));
      fwd_wb_data    = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
